// File: rtl/sha1_wb_sequencer.sv
// rtl/sha1_wb_sequencer.sv - Round-robin Wishbone master sharing one SHA1 engine between two requesters; optional abort via SHA1_SEQ_TIMEOUT_EN
module sha1_wb_sequencer #(
  parameter logic [31:0] BASE_ADDRESS  = 32'h30000024,
  parameter int unsigned POLL_GAP      = 8,
  parameter int unsigned TIMEOUT_POLLS = 64
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic [1:0]   req_i,
  output logic [1:0]   gnt_o,
  input  logic [1:0]   msg_valid_i,
  input  logic [63:0]  msg_data_i,
  output logic [1:0]   msg_ready_o,
  output logic [159:0] digest_o,
  output logic [1:0]   digest_valid_o,
  output logic [1:0]   err_o,
  output logic         wbm_cyc_o,
  output logic         wbm_stb_o,
  output logic         wbm_we_o,
  output logic [3:0]   wbm_sel_o,
  output logic [31:0]  wbm_adr_o,
  output logic [31:0]  wbm_dat_o,
  input  logic [31:0]  wbm_dat_i,
  input  logic         wbm_ack_i
);
  localparam logic [31:0] OPS_ADR = BASE_ADDRESS + 32'h8;
  localparam logic [31:0] MSG_ADR = BASE_ADDRESS + 32'hC;
  localparam logic [31:0] DIG_ADR = BASE_ADDRESS + 32'h10;
  localparam int unsigned GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int unsigned POLL_W = $clog2(TIMEOUT_POLLS + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_RST, S_MSGW, S_MSGB, S_GAP, S_POLL, S_DIG, S_DONE, S_ABORT
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          gnt_q, gnt_d;
  logic                ptr_q, ptr_d;
  logic [1:0]          ready_q, ready_d;
  logic [31:0]         word_q, word_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic [GAP_W-1:0]    gcnt_q, gcnt_d;
  logic [POLL_W-1:0]   pcnt_q, pcnt_d;
  logic [2:0]          dcnt_q, dcnt_d;
  logic [159:0]        digest_q, digest_d;
  logic [1:0]          dvalid_q, dvalid_d;
  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [3:0]          sel_q, sel_d;
  logic [31:0]         adr_q, adr_d;
  logic [31:0]         dat_q, dat_d;
`ifdef SHA1_SEQ_TIMEOUT_EN
  logic [1:0]          err_q, err_d;
  assign err_o = err_q;
`else
  assign err_o = 2'b00;
`endif

  logic        nxt;
  logic        ack_in;
  logic [31:0] word_in;
  assign nxt     = ~ptr_q;
  assign ack_in  = cyc_q & wbm_ack_i;
  assign word_in = gnt_q[1] ? msg_data_i[63:32] : msg_data_i[31:0];

  assign gnt_o          = gnt_q;
  assign msg_ready_o    = ready_q;
  assign digest_o       = digest_q;
  assign digest_valid_o = dvalid_q;
  assign wbm_cyc_o      = cyc_q;
  assign wbm_stb_o      = cyc_q;
  assign wbm_we_o       = we_q;
  assign wbm_sel_o      = sel_q;
  assign wbm_adr_o      = adr_q;
  assign wbm_dat_o      = dat_q;

  // Sequencer next state: arbitration, block streaming, polling, digest readback and bus launch
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    ready_d  = ready_q;
    word_d   = word_q;
    wcnt_d   = wcnt_q;
    gcnt_d   = gcnt_q;
    pcnt_d   = pcnt_q;
    dcnt_d   = dcnt_q;
    digest_d = digest_q;
    dvalid_d = 2'b00;
    cyc_d    = cyc_q;
    we_d     = we_q;
    sel_d    = sel_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
`ifdef SHA1_SEQ_TIMEOUT_EN
    err_d    = 2'b00;
`endif
    // a sampled ack ends the access; the following cycle is the mandatory idle cycle
    if (ack_in) begin
      cyc_d = 1'b0;
      we_d  = 1'b0;
      sel_d = 4'h0;
      adr_d = 32'h0;
      dat_d = 32'h0;
    end
    case (state_q)
      S_IDLE: if (|req_i) state_d = S_ARB;
      S_ARB: begin
        wcnt_d = 4'd0;
        pcnt_d = '0;
        dcnt_d = 3'd0;
        if (req_i[nxt]) begin
          gnt_d   = 2'b01 << nxt;
          ptr_d   = nxt;
          state_d = S_RST;
        end else if (req_i[ptr_q]) begin
          gnt_d   = 2'b01 << ptr_q;
          state_d = S_RST;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RST: if (ack_in) begin
        state_d = S_MSGW;
        ready_d = gnt_q;
      end
      S_MSGW: if (|(ready_q & msg_valid_i)) begin
        ready_d = 2'b00;
        word_d  = word_in;
        state_d = S_MSGB;
      end
      S_MSGB: if (ack_in) begin
        wcnt_d = wcnt_q + 4'd1;
        if (wcnt_q == 4'd15) begin
          gcnt_d  = '0;
          state_d = S_GAP;
        end else begin
          ready_d = gnt_q;
          state_d = S_MSGW;
        end
      end
      S_GAP: begin
        if (gcnt_q == GAP_W'(POLL_GAP - 1)) state_d = S_POLL;
        else gcnt_d = gcnt_q + GAP_W'(1);
      end
      S_POLL: if (ack_in) begin
        if (wbm_dat_i[3]) begin
          dcnt_d  = 3'd0;
          state_d = S_DIG;
        end else begin
          if (pcnt_q != POLL_W'(TIMEOUT_POLLS)) pcnt_d = pcnt_q + POLL_W'(1);
          gcnt_d  = '0;
          state_d = S_GAP;
`ifdef SHA1_SEQ_TIMEOUT_EN
          if (pcnt_q >= POLL_W'(TIMEOUT_POLLS - 1)) state_d = S_ABORT;
`endif
        end
      end
      S_DIG: if (ack_in) begin
        // h4 arrives first and lands in the low word
        digest_d[{dcnt_q, 5'd0} +: 32] = wbm_dat_i;
        if (dcnt_q == 3'd4) state_d = S_DONE;
        else dcnt_d = dcnt_q + 3'd1;
      end
      S_DONE: begin
        dvalid_d = gnt_q;
        gnt_d    = 2'b00;
        state_d  = S_IDLE;
      end
      S_ABORT: begin
`ifdef SHA1_SEQ_TIMEOUT_EN
        if (ack_in) begin
          err_d   = gnt_q;
          gnt_d   = 2'b00;
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    // start the access owned by the state being entered (or held) once the bus is free
    if (!cyc_q) begin
      case (state_d)
        S_RST, S_ABORT: begin
          cyc_d = 1'b1; we_d = 1'b1; sel_d = 4'hF; adr_d = OPS_ADR; dat_d = 32'h2;
        end
        S_MSGB: begin
          cyc_d = 1'b1; we_d = 1'b1; sel_d = 4'hF; adr_d = MSG_ADR; dat_d = word_d;
        end
        S_POLL: begin
          cyc_d = 1'b1; we_d = 1'b0; sel_d = 4'hF; adr_d = OPS_ADR; dat_d = 32'h0;
        end
        S_DIG: begin
          cyc_d = 1'b1; we_d = 1'b0; sel_d = 4'hF; adr_d = DIG_ADR; dat_d = 32'h0;
        end
        default: ;
      endcase
    end
  end

  // State and registered outputs; reset drops the bus immediately and points round-robin at requester 1
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      gnt_q    <= 2'b00;
      ptr_q    <= 1'b1;
      ready_q  <= 2'b00;
      word_q   <= 32'h0;
      wcnt_q   <= 4'd0;
      gcnt_q   <= '0;
      pcnt_q   <= '0;
      dcnt_q   <= 3'd0;
      digest_q <= 160'h0;
      dvalid_q <= 2'b00;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      sel_q    <= 4'h0;
      adr_q    <= 32'h0;
      dat_q    <= 32'h0;
`ifdef SHA1_SEQ_TIMEOUT_EN
      err_q    <= 2'b00;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
      ready_q  <= ready_d;
      word_q   <= word_d;
      wcnt_q   <= wcnt_d;
      gcnt_q   <= gcnt_d;
      pcnt_q   <= pcnt_d;
      dcnt_q   <= dcnt_d;
      digest_q <= digest_d;
      dvalid_q <= dvalid_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
`ifdef SHA1_SEQ_TIMEOUT_EN
      err_q    <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_sha1_wb_sequencer.sv
// tb/tb_sha1_wb_sequencer.sv - Directed scoreboard bench for sha1_wb_sequencer with a SHA1 Wishbone slave model
module tb_sha1_wb_sequencer;
  localparam logic [31:0] OPS = 32'h3000002C;
  localparam logic [31:0] MSG = 32'h30000030;
  localparam logic [31:0] DIG = 32'h30000034;
  localparam logic [159:0] ABC_DIG = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  typedef logic [31:0] blk_t [16];
  typedef struct { logic [1:0] gnt; logic [159:0] dig; } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0] req, gnt, mvalid, mready, dvalid, err;
  logic [63:0] mdata;
  logic [159:0] digest;
  logic cyc, stb, we, ack;
  logic [3:0] sel;
  logic [31:0] adr, wdat, rdat;

  sha1_wb_sequencer dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_i(req), .gnt_o(gnt),
    .msg_valid_i(mvalid), .msg_data_i(mdata), .msg_ready_o(mready),
    .digest_o(digest), .digest_valid_o(dvalid), .err_o(err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_dat_i(rdat), .wbm_ack_i(ack)
  );

  int checks = 0;
  int passes = 0;
  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [159:0] sha1_blk(input blk_t m);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = m[i];
    for (int i = 16; i < 80; i++) begin
      t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    a = 32'h67452301; b = 32'hEFCDAB89; c = 32'h98BADCFE; d = 32'h10325476; e = 32'hC3D2E1F0;
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {a + 32'h67452301, b + 32'hEFCDAB89, c + 32'h98BADCFE, d + 32'h10325476, e + 32'hC3D2E1F0};
  endfunction

  // SHA1 slave model
  int ack_dly = 0;
  bit never_done = 0;
  logic slv_ack = 1'b0;
  logic [31:0] slv_rdat = 32'h0;
  blk_t slv_w;
  int slv_n = 0, slv_wait = 0, slv_didx = 0, slv_cnt = 0;
  logic slv_done = 1'b0, slv_go = 1'b0;
  logic [159:0] slv_dig = 160'h0;
  int n_ops2 = 0, n_msg = 0, n_poll = 0, n_dig = 0, n_bad = 0;
  assign ack  = slv_ack;
  assign rdat = slv_rdat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      slv_ack <= 1'b0; slv_rdat <= 32'h0; slv_n <= 0; slv_wait <= 0; slv_didx <= 0;
      slv_cnt <= 0; slv_done <= 1'b0; slv_go <= 1'b0;
    end else begin
      slv_go <= 1'b0;
      if (slv_go) begin
        slv_dig <= sha1_blk(slv_w);
        slv_wait <= 30;
      end else if (slv_wait > 0) begin
        slv_wait <= slv_wait - 1;
        if (slv_wait == 1 && !never_done) slv_done <= 1'b1;
      end
      if (slv_ack) slv_ack <= 1'b0;
      else if (cyc && stb) begin
        if (slv_cnt < ack_dly) slv_cnt <= slv_cnt + 1;
        else begin
          slv_cnt <= 0;
          slv_ack <= 1'b1;
          if (we && adr == OPS && wdat == 32'h2) begin
            n_ops2 <= n_ops2 + 1; slv_n <= 0; slv_done <= 1'b0; slv_didx <= 0; slv_wait <= 0;
          end else if (we && adr == MSG) begin
            n_msg <= n_msg + 1;
            slv_w[slv_n[3:0]] <= wdat;
            if (slv_n == 15) begin slv_go <= 1'b1; slv_n <= 0; end
            else slv_n <= slv_n + 1;
          end else if (!we && adr == OPS) begin
            n_poll <= n_poll + 1;
            slv_rdat <= {28'h0, slv_done, 3'b000};
          end else if (!we && adr == DIG) begin
            n_dig <= n_dig + 1;
            slv_rdat <= slv_dig[slv_didx*32 +: 32];
            slv_didx <= slv_didx + 1;
          end else n_bad <= n_bad + 1;
        end
      end
    end
  end

  // Bus / handshake monitor sampled mid-cycle
  int mon_bad = 0, len_bad = 0, cyc_cnt = 0, err_cnt = 0, cur_len = 0, last_len = 0;
  logic prev_cyc = 1'b0, prev_ack = 1'b0;
  logic [68:0] hold = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_cyc <= 1'b0; prev_ack <= 1'b0; cur_len <= 0;
    end else begin
      mon_bad <= mon_bad + int'(cyc !== stb) + int'(prev_ack && cyc)
                 + int'(cyc && prev_cyc && !prev_ack && ({we, sel, adr, wdat} !== hold))
                 + int'(cyc && sel !== 4'hF) + int'((mready & ~gnt) !== 2'b00);
      if (cyc) begin
        cyc_cnt <= cyc_cnt + 1;
        cur_len <= cur_len + 1;
        if (ack) begin
          last_len <= cur_len + 1;
          if (cur_len + 1 != ack_dly + 2) len_bad <= len_bad + 1;
        end
      end else cur_len <= 0;
      if (err !== 2'b00) err_cnt <= err_cnt + 1;
      hold <= {we, sel, adr, wdat};
      prev_cyc <= cyc;
      prev_ack <= cyc && ack;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_grant(input string tag, output logic [1:0] g);
    int n = 0;
    while (gnt == 2'b00 && n < 100) begin @(negedge clk); n++; end
    chk({tag, "_grant_wait"}, n < 100, 1);
    g = gnt;
  endtask

  task automatic send_word(input int r, input logic [31:0] w);
    int n = 0;
    mvalid[r] = 1'b1;
    if (r == 0) mdata[31:0] = w; else mdata[63:32] = w;
    while (!mready[r] && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) chk("word_wait", n, 0);
    @(negedge clk);
    mvalid[r] = 1'b0;
  endtask

  task automatic send_block(input int r, input blk_t w, input int stall_after);
    int c0;
    for (int i = 0; i < 16; i++) begin
      send_word(r, w[i]);
      if (i == stall_after) begin
        repeat (5) @(negedge clk);
        c0 = cyc_cnt;
        repeat (45) @(negedge clk);
        chk("stall_quiet", cyc_cnt - c0, 0);
        chk("stall_ready", mready[r], 1);
      end
    end
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    exp_t e;
    while (dvalid == 2'b00 && n < 3000) begin @(negedge clk); n++; end
    chk({tag, "_result_wait"}, n < 3000, 1);
    if (n < 3000 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_dvalid"}, dvalid, e.gnt);
      chk({tag, "_digest"}, digest, e.dig);
      chk({tag, "_gnt_clr"}, gnt, 0);
      @(negedge clk);
      chk({tag, "_pulse"}, dvalid, 0);
    end
  endtask

  blk_t abc, rb;
  logic [1:0] g, expg;
  logic rr_ptr;
  int s_ops, s_msg, s_poll, s_dig, s_err;

  initial begin
    rst = 1'b1; req = 2'b00; mvalid = 2'b00; mdata = 64'h0;
    for (int i = 0; i < 16; i++) abc[i] = 32'h0;
    abc[0] = 32'h61626380; abc[15] = 32'h00000018;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {gnt, mready, dvalid, err, cyc, stb, we, sel}, 0);
    chk("rst_bus", {adr, wdat}, 0);
    chk("rst_digest", digest, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single "abc" block from requester 0
    s_ops = n_ops2; s_msg = n_msg; s_poll = n_poll; s_dig = n_dig;
    req = 2'b01;
    wait_grant("t1", g);
    chk("t1_gnt", g, 2'b01);
    req = 2'b00;
    sb_q.push_back('{gnt: 2'b01, dig: ABC_DIG});
    send_block(0, abc, -1);
    wait_result("t1");
    chk("t1_ops_wr", n_ops2 - s_ops, 1);
    chk("t1_msg_wr", n_msg - s_msg, 16);
    chk("t1_dig_rd", n_dig - s_dig, 5);
    chk("t1_polls", (n_poll - s_poll) >= 2, 1);

    // 2: both requesting for three blocks alternate from a fresh reset
    do_reset();
    rr_ptr = 1'b1;
    req = 2'b11;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) rb[i] = $urandom;
      wait_grant("t2", g);
      expg = rr_ptr ? 2'b01 : 2'b10;
      rr_ptr = ~rr_ptr;
      chk("t2_gnt", g, expg);
      if (b == 2) req = 2'b00;
      sb_q.push_back('{gnt: expg, dig: sha1_blk(rb)});
      send_block(expg[1] ? 1 : 0, rb, -1);
      wait_result("t2");
    end

    // 3: requester 1 stalls 50 cycles after word 7
    s_msg = n_msg;
    for (int i = 0; i < 16; i++) rb[i] = $urandom;
    req = 2'b10;
    wait_grant("t3", g);
    chk("t3_gnt", g, 2'b10);
    req = 2'b00;
    sb_q.push_back('{gnt: 2'b10, dig: sha1_blk(rb)});
    send_block(1, rb, 7);
    wait_result("t3");
    chk("t3_msg_wr", n_msg - s_msg, 16);

    // 4: slow slave, ack after 5 extra cycles
    ack_dly = 5;
    req = 2'b01;
    wait_grant("t4", g);
    chk("t4_gnt", g, 2'b01);
    req = 2'b00;
    sb_q.push_back('{gnt: 2'b01, dig: ABC_DIG});
    send_block(0, abc, -1);
    wait_result("t4");
    chk("t4_stb_len", last_len, 7);
    ack_dly = 0;

    // 5: reset in the middle of a MSG_IN write
    req = 2'b01;
    wait_grant("t5", g);
    for (int i = 0; i < 3; i++) send_word(0, abc[i]);
    chk("t5_in_msgb", {cyc, we, adr}, {2'b11, MSG});
    #1 rst = 1'b1;
    #1 chk("t5_drop", {cyc, stb, gnt}, 0);
    @(negedge clk);
    req = 2'b10;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) rb[i] = $urandom;
    wait_grant("t5a", g);
    chk("t5_gnt_r1", g, 2'b10);
    req = 2'b00;
    sb_q.push_back('{gnt: 2'b10, dig: sha1_blk(rb)});
    send_block(1, rb, -1);
    wait_result("t5");
    rst = 1'b1;
    req = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    wait_grant("t5b", g);
    chk("t5_gnt_r0", g, 2'b01);
    req = 2'b00;
    do_reset();

    // 6: slave never reports done
    never_done = 1;
    s_ops = n_ops2; s_poll = n_poll; s_err = err_cnt;
    req = 2'b01;
    wait_grant("t6", g);
    req = 2'b00;
    send_block(0, abc, -1);
    for (int n = 0; n < 1000 && err == 2'b00; n++) @(negedge clk);
`ifdef SHA1_SEQ_TIMEOUT_EN
    chk("t6_err", err, 2'b01);
    chk("t6_gnt", gnt, 0);
    chk("t6_polls", n_poll - s_poll, 64);
    chk("t6_ops_wr", n_ops2 - s_ops, 2);
`else
    chk("t6_err", err_cnt - s_err, 0);
    chk("t6_gnt", gnt, 2'b01);
    chk("t6_polls", (n_poll - s_poll) > 64, 1);
    chk("t6_ops_wr", n_ops2 - s_ops, 1);
`endif
    do_reset();
    never_done = 0;

    chk("bus_protocol", mon_bad, 0);
    chk("bus_stb_len", len_bad, 0);
    chk("slave_decode", n_bad, 0);
    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
